pipelined_control_unit: RTL and testbench
=========================================

PIPELINED_CONTROL_UNIT -- requirements
Module: pipelined_control_unit

Interface
REQ-001 SHALL have parameter MUL_LATENCY, default 3: MUL/MULH* execute cycles, minimum 1.
REQ-002 SHALL have parameter DIV_LATENCY, default 33: DIV/DIVU/REM/REMU execute cycles, minimum 1.
REQ-003 SHALL have port CLK  in  1: single clock, all state updates on the rising edge.
REQ-004 SHALL have port RESET  in  1: synchronous, active-high reset.
REQ-005 SHALL have port INSTRUCTION  in  32: RV32IM instruction from the IF/ID register.
REQ-006 SHALL have port VALID_IN  in  1: INSTRUCTION is valid.
REQ-007 SHALL have port STALL  in  1: hazard unit hold; registered outputs keep their values.
REQ-008 SHALL have port FLUSH  in  1: replace the registered outputs with a bubble.
REQ-009 SHALL have ports OP1_SEL  out  1 (1=PC) and OP2_SEL  out  1 (1=immediate).
REQ-010 SHALL have ports REG_WRITE_EN  out  1, IMM_SEL  out  3, BR_SEL  out  4, ALU_OP  out  5.
REQ-011 SHALL have ports MEM_WRITE  out  3, MEM_READ  out  4, REG_WRITE_SEL  out  2 (00 ALU, 01 memory, 10 PC+4).
REQ-012 SHALL have ports VALID_OUT  out  1, ILLEGAL  out  1 and STALL_REQ  out  1 (multi-cycle op in progress).

Function
REQ-013 SHALL register all decoded outputs: one-cycle latency from INSTRUCTION to the ID/EX control outputs.
REQ-014 SHALL use IMM_SEL encodings I=000, S=001, B=010, U=011, J=100, none=101.
REQ-015 SHALL set ALU_OP to {funct7[0], funct7[5], funct3} for OP instructions.
REQ-016 SHALL set ALU_OP to {0, funct3==101 ? funct7[5] : 0, funct3} for OP-IMM instructions.
REQ-017 SHALL set ALU_OP to 00000 for load/store/AUIPC/JAL/JALR/branch and to 11111 for LUI.
REQ-018 SHALL set BR_SEL to {1, funct3} for branches, 0010 for JAL/JALR and 0000 otherwise.
REQ-019 SHALL set MEM_READ to {1, funct3} for loads, MEM_WRITE to {1, funct3[1:0]} for stores, and both to 0 otherwise.
REQ-020 SHALL set OP1_SEL=1 only for AUIPC/JAL, and OP2_SEL=1 for all types except OP and branch.
REQ-021 SHALL set REG_WRITE_EN=1 for OP, OP-IMM, LOAD, LUI, AUIPC, JAL and JALR, irrespective of rd.
REQ-022 SHALL treat any unknown opcode, or any unsupported funct7, as illegal: ILLEGAL=1 and VALID_OUT=1 with REG_WRITE_EN, MEM_READ, MEM_WRITE and BR_SEL all 0.
REQ-023 SHALL register a bubble when VALID_IN=0: VALID_OUT=0 and every control output 0.
REQ-024 SHALL give the edge update priority RESET > FLUSH > (state BUSY or STALL: hold) > load decode.
REQ-025 SHALL load FLUSH as a bubble (all outputs 0) regardless of STALL, VALID_IN or state.
REQ-026 SHALL implement an FSM with states IDLE and BUSY, and drive STALL_REQ = (state==BUSY) combinationally from state only.
REQ-027 SHALL enter BUSY when a mul/div with latency L>1 is loaded in IDLE, loading a counter with L-1; STALL_REQ is then high for exactly L-1 cycles.
REQ-028 SHALL, in BUSY, decrement the counter each edge, return to IDLE on the edge where the counter equals 1, hold all registered outputs, and ignore INSTRUCTION/VALID_IN/STALL.
REQ-029 SHALL leave the FSM in IDLE (no stall) when L=1.
REQ-030 SHALL size the counter as $clog2(max(MUL_LATENCY, DIV_LATENCY)) bits with no wrap-around, since it is only loaded with L-1.
REQ-031 SHALL, on FLUSH in BUSY, return to IDLE on the same edge, clear the counter and drop STALL_REQ.

Reset
REQ-032 SHALL, with RESET high at an edge, clear all outputs to 0, set the state to IDLE and the counter to 0, overriding FLUSH/STALL.
REQ-033 SHALL, on RESET mid-BUSY, abort the operation; the first instruction after reset release is decoded normally.

Configuration
REQ-034 SHALL, with macro M_EXT_EN defined, decode funct7=0000001 on OP as MUL (funct3[2]=0, MUL_LATENCY) or DIV/REM (funct3[2]=1, DIV_LATENCY).
REQ-035 SHALL, without M_EXT_EN, decode those encodings as illegal and remove the FSM and counter (STALL_REQ tied 0).

Verification
REQ-036 SHALL cover: 0x00208033 -> next edge VALID_OUT=1, REG_WRITE_EN=1, ALU_OP=00000, OP2_SEL=0, IMM_SEL=101, REG_WRITE_SEL=00, STALL_REQ=0.
REQ-037 SHALL cover: 0x00812283 (lw) -> MEM_READ=1010, REG_WRITE_SEL=01, OP2_SEL=1, IMM_SEL=000, MEM_WRITE=000.
REQ-038 SHALL cover: M_EXT_EN, DIV_LATENCY=33, 0x0220C1B3 -> ALU_OP=10100, STALL_REQ high exactly 32 cycles, outputs held throughout.
REQ-039 SHALL cover: FLUSH at the 10th BUSY cycle of the scenario in REQ-038 -> next edge VALID_OUT=0, all outputs 0, STALL_REQ=0, next instruction decoded.
REQ-040 SHALL cover: STALL=1 with a new add -> outputs unchanged; STALL=1 with FLUSH=1 -> bubble.
REQ-041 SHALL cover: without M_EXT_EN, 0x0220C1B3 -> ILLEGAL=1, REG_WRITE_EN=0, STALL_REQ=0.

Source files
------------

// File: rtl/pipelined_control_unit.sv
// ID-stage control decoder for RV32I(M) with a registered ID/EX control bundle.
// Define M_EXT_EN to decode MUL/DIV/REM and enable the multi-cycle stall FSM.
module pipelined_control_unit #(
   parameter int MUL_LATENCY = 3,
   parameter int DIV_LATENCY = 33
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [31:0] INSTRUCTION,
   input  logic        VALID_IN,
   input  logic        STALL,
   input  logic        FLUSH,
   output logic        OP1_SEL,
   output logic        OP2_SEL,
   output logic        REG_WRITE_EN,
   output logic [2:0]  IMM_SEL,
   output logic [3:0]  BR_SEL,
   output logic [4:0]  ALU_OP,
   output logic [2:0]  MEM_WRITE,
   output logic [3:0]  MEM_READ,
   output logic [1:0]  REG_WRITE_SEL,
   output logic        VALID_OUT,
   output logic        ILLEGAL,
   output logic        STALL_REQ
);

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   localparam logic [2:0] IMM_I    = 3'b000;
   localparam logic [2:0] IMM_S    = 3'b001;
   localparam logic [2:0] IMM_B    = 3'b010;
   localparam logic [2:0] IMM_U    = 3'b011;
   localparam logic [2:0] IMM_J    = 3'b100;
   localparam logic [2:0] IMM_NONE = 3'b101;

   localparam logic [1:0] WB_ALU = 2'b00;
   localparam logic [1:0] WB_MEM = 2'b01;
   localparam logic [1:0] WB_PC4 = 2'b10;

   typedef struct packed {
      logic       op1_sel;
      logic       op2_sel;
      logic       reg_write_en;
      logic [2:0] imm_sel;
      logic [3:0] br_sel;
      logic [4:0] alu_op;
      logic [2:0] mem_write;
      logic [3:0] mem_read;
      logic [1:0] reg_write_sel;
      logic       valid;
      logic       illegal;
   } ctrl_t;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic       unused_fields;

   assign opcode        = INSTRUCTION[6:0];
   assign funct3        = INSTRUCTION[14:12];
   assign funct7        = INSTRUCTION[31:25];
   assign unused_fields = ^{INSTRUCTION[24:15], INSTRUCTION[11:7]};

   ctrl_t dec;
   ctrl_t ctrl_q;
   logic  bad;
   logic  load_en;
`ifdef M_EXT_EN
   logic  dec_mul;
   logic  dec_div;
`endif

   always_comb begin
      // NOTE: every variable is given a default first so no path can infer a latch.
      dec = '0;
      bad = 1'b0;
`ifdef M_EXT_EN
      dec_mul = 1'b0;
      dec_div = 1'b0;
`endif
      if (VALID_IN) begin
         dec.valid = 1'b1;
         case (opcode)
            OPC_OP: begin
               dec.reg_write_en = 1'b1;
               dec.imm_sel      = IMM_NONE;
               dec.alu_op       = {funct7[0], funct7[5], funct3};
               if (funct7 == F7_BASE) begin
                  bad = 1'b0;
               end else if (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)) begin
                  bad = 1'b0;
`ifdef M_EXT_EN
               end else if (funct7 == F7_MULDIV) begin
                  dec_mul = ~funct3[2];
                  dec_div = funct3[2];
`endif
               end else begin
                  bad = 1'b1;
               end
            end
            OPC_OP_IMM: begin
               dec.reg_write_en = 1'b1;
               dec.op2_sel      = 1'b1;
               dec.imm_sel      = IMM_I;
               dec.alu_op       = {1'b0, (funct3 == 3'b101) ? funct7[5] : 1'b0, funct3};
               // Only the shift forms carry a funct7; the rest hold immediate bits there.
               if (funct3 == 3'b001 && funct7 != F7_BASE) bad = 1'b1;
               if (funct3 == 3'b101 && funct7 != F7_BASE && funct7 != F7_ALT) bad = 1'b1;
            end
            OPC_LOAD: begin
               dec.reg_write_en  = 1'b1;
               dec.op2_sel       = 1'b1;
               dec.imm_sel       = IMM_I;
               dec.mem_read      = {1'b1, funct3};
               dec.reg_write_sel = WB_MEM;
            end
            OPC_STORE: begin
               dec.op2_sel   = 1'b1;
               dec.imm_sel   = IMM_S;
               dec.mem_write = {1'b1, funct3[1:0]};
            end
            OPC_BRANCH: begin
               dec.imm_sel = IMM_B;
               dec.br_sel  = {1'b1, funct3};
            end
            OPC_LUI: begin
               dec.reg_write_en = 1'b1;
               dec.op2_sel      = 1'b1;
               dec.imm_sel      = IMM_U;
               dec.alu_op       = 5'b11111;
            end
            OPC_AUIPC: begin
               dec.reg_write_en = 1'b1;
               dec.op1_sel      = 1'b1;
               dec.op2_sel      = 1'b1;
               dec.imm_sel      = IMM_U;
            end
            OPC_JAL: begin
               dec.reg_write_en  = 1'b1;
               dec.op1_sel       = 1'b1;
               dec.op2_sel       = 1'b1;
               dec.imm_sel       = IMM_J;
               dec.br_sel        = 4'b0010;
               dec.reg_write_sel = WB_PC4;
            end
            OPC_JALR: begin
               dec.reg_write_en  = 1'b1;
               dec.op2_sel       = 1'b1;
               dec.imm_sel       = IMM_I;
               dec.br_sel        = 4'b0010;
               dec.reg_write_sel = WB_PC4;
            end
            default: bad = 1'b1;
         endcase
         if (bad) begin
            dec         = '0;
            dec.valid   = 1'b1;
            dec.illegal = 1'b1;
         end
      end
   end

`ifdef M_EXT_EN
   typedef enum logic {IDLE, BUSY} state_e;

   localparam int MAX_LAT = (MUL_LATENCY > DIV_LATENCY) ? MUL_LATENCY : DIV_LATENCY;
   localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
   localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LATENCY - 1);
   localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LATENCY - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      load_en = 1'b0;
      if (FLUSH) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else if (state_q == BUSY) begin
         cnt_d = cnt_q - 1'b1;
         if (cnt_q == CNT_W'(1)) state_d = IDLE;
      end else if (!STALL) begin
         load_en = 1'b1;
         if (!bad && dec_mul && MUL_LATENCY > 1) begin
            state_d = BUSY;
            cnt_d   = MUL_CNT;
         end else if (!bad && dec_div && DIV_LATENCY > 1) begin
            state_d = BUSY;
            cnt_d   = DIV_CNT;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign STALL_REQ = (state_q == BUSY);
`else
   localparam int unused_latency_sum = MUL_LATENCY + DIV_LATENCY;

   assign load_en   = ~FLUSH & ~STALL;
   assign STALL_REQ = 1'b0;
`endif

   always_ff @(posedge CLK) begin
      if (RESET || FLUSH) begin
         ctrl_q <= '0;
      end else if (load_en) begin
         ctrl_q <= dec;
      end
   end

   assign OP1_SEL       = ctrl_q.op1_sel;
   assign OP2_SEL       = ctrl_q.op2_sel;
   assign REG_WRITE_EN  = ctrl_q.reg_write_en;
   assign IMM_SEL       = ctrl_q.imm_sel;
   assign BR_SEL        = ctrl_q.br_sel;
   assign ALU_OP        = ctrl_q.alu_op;
   assign MEM_WRITE     = ctrl_q.mem_write;
   assign MEM_READ      = ctrl_q.mem_read;
   assign REG_WRITE_SEL = ctrl_q.reg_write_sel;
   assign VALID_OUT     = ctrl_q.valid;
   assign ILLEGAL       = ctrl_q.illegal;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Self-checking bench for pipelined_control_unit: decode table, multi-cycle corner
// sequences and a randomized run against an instruction-level reference model.
module tb_pipelined_control_unit;

   localparam int MUL_LAT = 3;
   localparam int DIV_LAT = 33;
`ifdef M_EXT_EN
   localparam bit M_EXT = 1'b1;
`else
   localparam bit M_EXT = 1'b0;
`endif

   logic        CLK = 1'b0;
   logic        RESET, VALID_IN, STALL, FLUSH;
   logic [31:0] INSTRUCTION;
   logic        OP1_SEL, OP2_SEL, REG_WRITE_EN, VALID_OUT, ILLEGAL, STALL_REQ;
   logic [2:0]  IMM_SEL, MEM_WRITE;
   logic [3:0]  BR_SEL, MEM_READ;
   logic [4:0]  ALU_OP;
   logic [1:0]  REG_WRITE_SEL;

   pipelined_control_unit #(.MUL_LATENCY(MUL_LAT), .DIV_LATENCY(DIV_LAT)) dut (
      .CLK(CLK), .RESET(RESET), .INSTRUCTION(INSTRUCTION), .VALID_IN(VALID_IN),
      .STALL(STALL), .FLUSH(FLUSH), .OP1_SEL(OP1_SEL), .OP2_SEL(OP2_SEL),
      .REG_WRITE_EN(REG_WRITE_EN), .IMM_SEL(IMM_SEL), .BR_SEL(BR_SEL), .ALU_OP(ALU_OP),
      .MEM_WRITE(MEM_WRITE), .MEM_READ(MEM_READ), .REG_WRITE_SEL(REG_WRITE_SEL),
      .VALID_OUT(VALID_OUT), .ILLEGAL(ILLEGAL), .STALL_REQ(STALL_REQ)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic       valid, illegal, we, op1, op2;
      logic [2:0] imm;
      logic [3:0] br;
      logic [4:0] alu;
      logic [2:0] mw;
      logic [3:0] mr;
      logic [1:0] rws;
   } ctl_t;

   typedef struct {
      string       name;
      logic [31:0] instr;
      logic        valid;
      ctl_t        exp;
   } vec_t;

   typedef enum {K_LUI, K_AUIPC, K_JAL, K_JALR, K_BR, K_LD, K_ST, K_IMM, K_REG,
                 K_MUL, K_DIV, K_BAD} kind_e;

   int n_checks = 0;
   int n_pass   = 0;

   function automatic ctl_t mk(bit v, bit il, bit we, bit o1, bit o2, logic [2:0] imm,
                               logic [3:0] br, logic [4:0] alu, logic [2:0] mw,
                               logic [3:0] mr, logic [1:0] rws);
      ctl_t c;
      c = '{v, il, we, o1, o2, imm, br, alu, mw, mr, rws};
      return c;
   endfunction

   function automatic ctl_t observed();
      return mk(VALID_OUT, ILLEGAL, REG_WRITE_EN, OP1_SEL, OP2_SEL, IMM_SEL, BR_SEL,
                ALU_OP, MEM_WRITE, MEM_READ, REG_WRITE_SEL);
   endfunction

   // Illegal instructions only pin down the valid/illegal/write/memory/branch fields.
   function automatic ctl_t visible(ctl_t c);
      ctl_t r;
      r = c;
      if (c.illegal) begin
         r.op1 = 1'b0; r.op2 = 1'b0; r.imm = '0; r.alu = '0; r.rws = '0;
      end
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic check_ctl(input string name, input ctl_t exp);
      check(name, 32'(visible(observed())), 32'(visible(exp)));
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic drive(input logic [31:0] i, input logic v, input logic s, input logic f);
      INSTRUCTION = i; VALID_IN = v; STALL = s; FLUSH = f;
   endtask

   // Reference model: classify the instruction, then read outputs off that class.
   function automatic kind_e classify(logic [31:0] i);
      logic [2:0] f3 = i[14:12];
      logic [6:0] f7 = i[31:25];
      case (i[6:0])
         7'h37: return K_LUI;
         7'h17: return K_AUIPC;
         7'h6F: return K_JAL;
         7'h67: return K_JALR;
         7'h63: return K_BR;
         7'h03: return K_LD;
         7'h23: return K_ST;
         7'h13: begin
            if (f3 == 3'd1 && f7 != 7'h00) return K_BAD;
            if (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20) return K_BAD;
            return K_IMM;
         end
         7'h33: begin
            if (f7 == 7'h00) return K_REG;
            if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) return K_REG;
            if (f7 == 7'h01 && M_EXT) return f3[2] ? K_DIV : K_MUL;
            return K_BAD;
         end
         default: return K_BAD;
      endcase
   endfunction

   function automatic ctl_t expect_of(logic [31:0] i, logic v);
      logic [2:0] f3 = i[14:12];
      logic [6:0] f7 = i[31:25];
      if (!v) return '0;
      case (classify(i))
         K_REG, K_MUL, K_DIV: return mk(1,0,1,0,0,3'd5,4'd0,{f7[0],f7[5],f3},3'd0,4'd0,2'd0);
         K_IMM: return mk(1,0,1,0,1,3'd0,4'd0,{1'b0,(f3==3'd5)?f7[5]:1'b0,f3},3'd0,4'd0,2'd0);
         K_LD:  return mk(1,0,1,0,1,3'd0,4'd0,5'd0,3'd0,{1'b1,f3},2'd1);
         K_ST:  return mk(1,0,0,0,1,3'd1,4'd0,5'd0,{1'b1,f3[1:0]},4'd0,2'd0);
         K_BR:  return mk(1,0,0,0,0,3'd2,{1'b1,f3},5'd0,3'd0,4'd0,2'd0);
         K_LUI: return mk(1,0,1,0,1,3'd3,4'd0,5'd31,3'd0,4'd0,2'd0);
         K_AUIPC: return mk(1,0,1,1,1,3'd3,4'd0,5'd0,3'd0,4'd0,2'd0);
         K_JAL: return mk(1,0,1,1,1,3'd4,4'd2,5'd0,3'd0,4'd0,2'd2);
         K_JALR: return mk(1,0,1,0,1,3'd0,4'd2,5'd0,3'd0,4'd0,2'd2);
         default: return mk(1,1,0,0,0,3'd0,4'd0,5'd0,3'd0,4'd0,2'd0);
      endcase
   endfunction

   function automatic int latency_of(logic [31:0] i, logic v);
      if (!v) return 0;
      case (classify(i))
         K_MUL:   return MUL_LAT;
         K_DIV:   return DIV_LAT;
         default: return 0;
      endcase
   endfunction

   localparam logic [31:0] I_ADD = 32'h00208033;
   localparam logic [31:0] I_LUI = 32'h123452B7;
   localparam logic [31:0] I_DIV = 32'h0220C1B3;
   localparam logic [31:0] I_MUL = 32'h022081B3;

   vec_t vecs[$];
   ctl_t add_exp, div_exp, mul_exp, m_q;
   int   cnt, m_busy, lat;
   logic [31:0] opcodes [10];

   initial begin
      add_exp = mk(1,0,1,0,0,3'b101,4'b0000,5'b00000,3'b000,4'b0000,2'b00);
      div_exp = mk(1,0,1,0,0,3'b101,4'b0000,5'b10100,3'b000,4'b0000,2'b00);
      mul_exp = mk(1,0,1,0,0,3'b101,4'b0000,5'b10000,3'b000,4'b0000,2'b00);
      vecs.push_back('{"add",   I_ADD,        1, add_exp});
      vecs.push_back('{"sub",   32'h40208033, 1, mk(1,0,1,0,0,3'b101,4'b0000,5'b01000,3'b000,4'b0000,2'b00)});
      vecs.push_back('{"lw",    32'h00812283, 1, mk(1,0,1,0,1,3'b000,4'b0000,5'b00000,3'b000,4'b1010,2'b01)});
      vecs.push_back('{"lbu",   32'h00814283, 1, mk(1,0,1,0,1,3'b000,4'b0000,5'b00000,3'b000,4'b1100,2'b01)});
      vecs.push_back('{"sw",    32'h00112423, 1, mk(1,0,0,0,1,3'b001,4'b0000,5'b00000,3'b110,4'b0000,2'b00)});
      vecs.push_back('{"beq",   32'h00208463, 1, mk(1,0,0,0,0,3'b010,4'b1000,5'b00000,3'b000,4'b0000,2'b00)});
      vecs.push_back('{"bltu",  32'h0020E463, 1, mk(1,0,0,0,0,3'b010,4'b1110,5'b00000,3'b000,4'b0000,2'b00)});
      vecs.push_back('{"lui",   I_LUI,        1, mk(1,0,1,0,1,3'b011,4'b0000,5'b11111,3'b000,4'b0000,2'b00)});
      vecs.push_back('{"auipc", 32'h00001097, 1, mk(1,0,1,1,1,3'b011,4'b0000,5'b00000,3'b000,4'b0000,2'b00)});
      vecs.push_back('{"jal",   32'h008000EF, 1, mk(1,0,1,1,1,3'b100,4'b0010,5'b00000,3'b000,4'b0000,2'b10)});
      vecs.push_back('{"jalr",  32'h000080E7, 1, mk(1,0,1,0,1,3'b000,4'b0010,5'b00000,3'b000,4'b0000,2'b10)});
      vecs.push_back('{"srai",  32'h40315093, 1, mk(1,0,1,0,1,3'b000,4'b0000,5'b01101,3'b000,4'b0000,2'b00)});
      vecs.push_back('{"addi_neg", 32'hFFF10093, 1, mk(1,0,1,0,1,3'b000,4'b0000,5'b00000,3'b000,4'b0000,2'b00)});
      vecs.push_back('{"bad_opcode", 32'h0000007F, 1, mk(1,1,0,0,0,3'b000,4'b0000,5'b00000,3'b000,4'b0000,2'b00)});
      vecs.push_back('{"bad_f7_op",  32'h60208033, 1, mk(1,1,0,0,0,3'b000,4'b0000,5'b00000,3'b000,4'b0000,2'b00)});
      vecs.push_back('{"bad_slli",   32'h40311093, 1, mk(1,1,0,0,0,3'b000,4'b0000,5'b00000,3'b000,4'b0000,2'b00)});
      vecs.push_back('{"bubble",     I_ADD,        0, '0});

      // Reset state
      RESET = 1'b1;
      drive(I_ADD, 1'b1, 1'b1, 1'b1);
      step();
      step();
      check_ctl("reset_outputs", '0);
      check("reset_stall_req", 32'(STALL_REQ), 32'd0);
      RESET = 1'b0;

      // Decode table
      foreach (vecs[k]) begin
         drive(vecs[k].instr, vecs[k].valid, 1'b0, 1'b0);
         step();
         check_ctl(vecs[k].name, vecs[k].exp);
         check({vecs[k].name, "_stall_req"}, 32'(STALL_REQ), 32'd0);
      end

      // STALL holds, FLUSH beats STALL
      drive(I_ADD, 1'b1, 1'b0, 1'b0);
      step();
      drive(I_LUI, 1'b1, 1'b1, 1'b0);
      step();
      check_ctl("stall_hold", add_exp);
      drive(I_LUI, 1'b1, 1'b1, 1'b1);
      step();
      check_ctl("stall_flush_bubble", '0);

      if (M_EXT) begin
         // Divide: STALL_REQ for DIV_LAT-1 cycles, outputs held, inputs ignored
         drive(I_DIV, 1'b1, 1'b0, 1'b0);
         step();
         check_ctl("div_decode", div_exp);
         drive(I_LUI, 1'b1, 1'b1, 1'b0);
         cnt = 0;
         while (STALL_REQ === 1'b1 && cnt < 100) begin
            cnt++;
            check_ctl("div_hold", div_exp);
            step();
         end
         check("div_stall_cycles", 32'(cnt), 32'(DIV_LAT - 1));
         check_ctl("div_hold_after_busy", div_exp);
         drive(I_ADD, 1'b1, 1'b0, 1'b0);
         step();
         check_ctl("after_div_add", add_exp);

         // Multiply: MUL_LAT-1 stall cycles
         drive(I_MUL, 1'b1, 1'b0, 1'b0);
         step();
         check_ctl("mul_decode", mul_exp);
         drive(I_ADD, 1'b1, 1'b0, 1'b0);
         cnt = 0;
         while (STALL_REQ === 1'b1 && cnt < 100) begin
            cnt++;
            step();
         end
         check("mul_stall_cycles", 32'(cnt), 32'(MUL_LAT - 1));

         // FLUSH on the 10th busy cycle
         drive(I_DIV, 1'b1, 1'b0, 1'b0);
         step();
         drive(I_ADD, 1'b1, 1'b0, 1'b0);
         repeat (9) step();
         check("flush_busy_before", 32'(STALL_REQ), 32'd1);
         drive(I_ADD, 1'b1, 1'b0, 1'b1);
         step();
         check_ctl("flush_busy_bubble", '0);
         check("flush_busy_stall_req", 32'(STALL_REQ), 32'd0);
         drive(I_ADD, 1'b1, 1'b0, 1'b0);
         step();
         check_ctl("flush_busy_next", add_exp);
         check("flush_busy_next_stall", 32'(STALL_REQ), 32'd0);

         // RESET mid-busy aborts the divide
         drive(I_DIV, 1'b1, 1'b0, 1'b0);
         step();
         repeat (5) step();
         RESET = 1'b1;
         drive(I_DIV, 1'b1, 1'b1, 1'b1);
         step();
         check_ctl("reset_busy_outputs", '0);
         check("reset_busy_stall_req", 32'(STALL_REQ), 32'd0);
         RESET = 1'b0;
         drive(I_ADD, 1'b1, 1'b0, 1'b0);
         step();
         check_ctl("reset_busy_next", add_exp);
      end else begin
         drive(I_DIV, 1'b1, 1'b0, 1'b0);
         step();
         check_ctl("div_illegal", mk(1,1,0,0,0,3'b000,4'b0000,5'b00000,3'b000,4'b0000,2'b00));
         check("div_illegal_stall_req", 32'(STALL_REQ), 32'd0);
         drive(I_ADD, 1'b1, 1'b0, 1'b0);
         step();
         check_ctl("after_illegal_add", add_exp);
      end

      // Randomized run against the model
      opcodes = '{32'h37, 32'h17, 32'h6F, 32'h67, 32'h63, 32'h03, 32'h23, 32'h13, 32'h33, 32'h0F};
      RESET = 1'b1;
      drive(I_ADD, 1'b0, 1'b0, 1'b0);
      step();
      RESET = 1'b0;
      m_q = '0;
      m_busy = 0;
      for (int n = 0; n < 1500; n++) begin
         logic [31:0] instr;
         logic [6:0]  f7;
         logic        v, s, f, r;
         instr = $urandom;
         case ($urandom_range(0, 3))
            0: f7 = 7'h00;
            1: f7 = 7'h20;
            2: f7 = 7'h01;
            default: f7 = instr[31:25];
         endcase
         instr[31:25] = f7;
         instr[6:0]   = opcodes[$urandom_range(0, 9)][6:0];
         v = ($urandom_range(0, 3) != 0);
         s = ($urandom_range(0, 3) == 0);
         f = ($urandom_range(0, 15) == 0);
         r = ($urandom_range(0, 63) == 0);
         RESET = r;
         drive(instr, v, s, f);
         if (r || f) begin
            m_q = '0;
            m_busy = 0;
         end else if (m_busy > 0) begin
            m_busy--;
         end else if (!s) begin
            m_q = expect_of(instr, v);
            lat = latency_of(instr, v);
            if (lat > 1) m_busy = lat - 1;
         end
         step();
         check_ctl("random_outputs", m_q);
         check("random_stall_req", 32'(STALL_REQ), 32'(m_busy > 0));
      end
      RESET = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
